// File: rtl/vedic_pkg.sv
// vedic_pkg: shared constants, state encoding and step shift lookup for the sequential vedic multiplier
package vedic_pkg;

    localparam int HALF_W = 3;
    localparam int OP_W   = 6;
    localparam int PROD_W = 2 * OP_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        MUL  = ST_MUL,
        DONE = ST_DONE
    } state_t;

    localparam logic [2:0] SH_STEP0 = 3'd0;
    localparam logic [2:0] SH_STEP1 = 3'd3;
    localparam logic [2:0] SH_STEP2 = 3'd3;
    localparam logic [2:0] SH_STEP3 = 3'd6;

    // Weight of the partial product produced at each step: lo*lo, hi*lo, lo*hi, hi*hi.
    function automatic logic [2:0] step_shift(input logic [1:0] s);
        return s == 2'd0 ? SH_STEP0 :
               s == 2'd1 ? SH_STEP1 :
               s == 2'd2 ? SH_STEP2 : SH_STEP3;
    endfunction

endpackage

// File: rtl/vedic_mul6_seq_if.sv
// vedic_mul6_seq_if: operand/product valid-ready bus for the sequential multiplier
interface vedic_mul6_seq_if;
    import vedic_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   a;
    logic [OP_W-1:0]   b;
    logic              out_valid;
    logic              out_ready;
    logic [PROD_W-1:0] product;
    logic              busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );

endinterface

// File: rtl/vedic3bit.sv
// vedic3bit: combinational 3x3 unsigned multiplier using urdhva-tiryagbhyam column sums
module vedic3bit (
    input  logic [2:0] a,
    input  logic [2:0] b,
    output logic [5:0] p
);

    logic [1:0] s1;
    logic [2:0] s2;
    logic [2:0] s3;
    logic [1:0] s4;

    // Each column sums its vertical/crosswise bit products plus the carry from the column below.
    always_comb begin
        s1 = 2'(a[1] & b[0]) + 2'(a[0] & b[1]);
        s2 = 3'(a[2] & b[0]) + 3'(a[1] & b[1]) + 3'(a[0] & b[2]) + 3'(s1[1]);
        s3 = 3'(a[2] & b[1]) + 3'(a[1] & b[2]) + 3'(s2[2:1]);
        s4 = 2'(a[2] & b[2]) + s3[2:1];
        p  = {s4, s3[0], s2[0], s1[0], a[0] & b[0]};
    end

endmodule

// File: rtl/vedic_mul6_seq.sv
// vedic_mul6_seq: 6x6 unsigned multiplier that runs four 3x3 partial products through one vedic3bit core
module vedic_mul6_seq
    import vedic_pkg::*;
#(
    parameter bit ZERO_SKIP = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    vedic_mul6_seq_if.slave  bus
);

    state_t            state, state_n;
    logic [1:0]        step, step_n;
    logic [OP_W-1:0]   a_q, b_q, a_n, b_n;
    logic [PROD_W-1:0] acc, acc_n, addend;
    logic [HALF_W-1:0] core_a, core_b;
    logic [OP_W-1:0]   pp;
    logic              in_ready_q, out_valid_q;
    logic [PROD_W-1:0] product_q;
    logic              accept, zero_op;

    assign core_a = step[0] ? a_q[OP_W-1:HALF_W] : a_q[HALF_W-1:0];
    assign core_b = step[1] ? b_q[OP_W-1:HALF_W] : b_q[HALF_W-1:0];

    vedic3bit u_core (
        .a (core_a),
        .b (core_b),
        .p (pp)
    );

    assign addend  = {{(PROD_W-OP_W){1'b0}}, pp} << step_shift(step);
    assign accept  = bus.in_valid && in_ready_q;
    assign zero_op = ZERO_SKIP && (bus.a == '0 || bus.b == '0);

    // Next state: latch operands on accept, accumulate one partial product per MUL cycle, wait for the consumer in DONE.
    always_comb begin
        state_n = state;
        step_n  = step;
        acc_n   = acc;
        a_n     = a_q;
        b_n     = b_q;
        case (state)
            IDLE: if (accept) begin
                a_n     = bus.a;
                b_n     = bus.b;
                acc_n   = '0;
                step_n  = '0;
                state_n = zero_op ? DONE : MUL;
            end
            MUL: begin
                acc_n   = acc + addend;
                step_n  = step + 2'd1;
                state_n = step == 2'd3 ? DONE : MUL;
            end
            DONE:    state_n = bus.out_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end

    // State and registered handshake outputs; product is forced to 0 outside DONE so partial sums never leak.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            step        <= '0;
            acc         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            product_q   <= '0;
        end else begin
            state       <= state_n;
            step        <= step_n;
            acc         <= acc_n;
            a_q         <= a_n;
            b_q         <= b_n;
            in_ready_q  <= state_n == IDLE;
            out_valid_q <= state_n == DONE;
            product_q   <= state_n == DONE ? acc_n : '0;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.product   = product_q;
    assign bus.busy      = state != IDLE;

endmodule

// File: tb/tb_vedic_mul6_seq.sv
// tb_vedic_mul6_seq: directed scenarios for the sequential 6x6 vedic multiplier
module tb_vedic_mul6_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    vedic_mul6_seq_if bus ();
    vedic_mul6_seq_if bus0 ();

    vedic_mul6_seq #(.ZERO_SKIP(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    vedic_mul6_seq #(.ZERO_SKIP(1'b0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    task automatic do_op(input logic [5:0] ai, input logic [5:0] bi,
                         output int edges, output logic [11:0] p, output logic saw_ready);
        bus.a = ai;
        bus.b = bi;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        edges = 0;
        saw_ready = bus.in_ready;
        while (!bus.out_valid && edges < 20) begin
            @(posedge clk); #1;
            edges++;
            saw_ready |= bus.in_ready;
        end
        p = bus.product;
    endtask

    task automatic release_op();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
        n_cmp++; if (bus.product !== 12'd0) begin n_err++; $display("FAIL rst_product got=%0d exp=0", bus.product); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL idle_in_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_basic();
        int e; logic [11:0] p; logic s;
        do_op(6'd45, 6'd27, e, p, s);
        n_cmp++; if (e !== 4) begin n_err++; $display("FAIL basic_latency got=%0d exp=4", e); end
        n_cmp++; if (p !== 12'd1215) begin n_err++; $display("FAIL basic_product got=%0d exp=1215", p); end
        n_cmp++; if (s !== 1'b0) begin n_err++; $display("FAIL basic_in_ready_busy got=%b exp=0", s); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL basic_busy got=%b exp=1", bus.busy); end
        release_op();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL basic_out_valid_drop got=%b exp=0", bus.out_valid); end
        n_cmp++; if (bus.product !== 12'd0) begin n_err++; $display("FAIL basic_product_idle got=%0d exp=0", bus.product); end
    endtask

    task automatic test_extremes();
        logic [5:0]  ta [2] = '{6'd63, 6'd1};
        logic [5:0]  tb [2] = '{6'd63, 6'd1};
        logic [11:0] tp [2] = '{12'd3969, 12'd1};
        int e; logic [11:0] p; logic s;
        for (int i = 0; i < 2; i++) begin
            do_op(ta[i], tb[i], e, p, s);
            n_cmp++; if (p !== tp[i]) begin n_err++; $display("FAIL extreme_product[%0d] got=%0d exp=%0d", i, p, tp[i]); end
            n_cmp++; if (e !== 4) begin n_err++; $display("FAIL extreme_latency[%0d] got=%0d exp=4", i, e); end
            release_op();
        end
    endtask

    task automatic test_zero_skip();
        int e; logic [11:0] p; logic s;
        do_op(6'd0, 6'd50, e, p, s);
        n_cmp++; if (e !== 0) begin n_err++; $display("FAIL zs_a0_latency got=%0d exp=0", e); end
        n_cmp++; if (p !== 12'd0) begin n_err++; $display("FAIL zs_a0_product got=%0d exp=0", p); end
        release_op();
        do_op(6'd9, 6'd0, e, p, s);
        n_cmp++; if (e !== 0) begin n_err++; $display("FAIL zs_b0_latency got=%0d exp=0", e); end
        n_cmp++; if (p !== 12'd0) begin n_err++; $display("FAIL zs_b0_product got=%0d exp=0", p); end
        release_op();
        bus0.a = 6'd0;
        bus0.b = 6'd50;
        bus0.in_valid = 1'b1;
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        e = 0;
        while (!bus0.out_valid && e < 20) begin
            @(posedge clk); #1;
            e++;
        end
        n_cmp++; if (e !== 4) begin n_err++; $display("FAIL nozs_latency got=%0d exp=4", e); end
        n_cmp++; if (bus0.product !== 12'd0) begin n_err++; $display("FAIL nozs_product got=%0d exp=0", bus0.product); end
        bus0.out_ready = 1'b1;
        @(posedge clk); #1;
        bus0.out_ready = 1'b0;
        n_cmp++; if (bus0.out_valid !== 1'b0) begin n_err++; $display("FAIL nozs_drop got=%b exp=0", bus0.out_valid); end
    endtask

    task automatic test_backpressure();
        int e; logic [11:0] p; logic s;
        do_op(6'd7, 6'd9, e, p, s);
        n_cmp++; if (p !== 12'd63) begin n_err++; $display("FAIL bp_product got=%0d exp=63", p); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.product !== 12'd63) begin
                n_err++;
                $display("FAIL bp_hold[%0d] got valid=%b product=%0d exp valid=1 product=63", i, bus.out_valid, bus.product);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drop got=%b exp=0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_in_ready got=%b exp=1", bus.in_ready); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL bp_busy got=%b exp=0", bus.busy); end
    endtask

    task automatic test_reset_mid();
        int e; logic [11:0] p; logic s;
        bus.a = 6'd20;
        bus.b = 6'd30;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL mid_busy_before got=%b exp=1", bus.busy); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL mid_out_valid got=%b exp=0", bus.out_valid); end
        n_cmp++; if (bus.product !== 12'd0) begin n_err++; $display("FAIL mid_product got=%0d exp=0", bus.product); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL mid_busy got=%b exp=0", bus.busy); end
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL mid_in_ready got=%b exp=0", bus.in_ready); end
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready_after got=%b exp=1", bus.in_ready); end
        do_op(6'd5, 6'd6, e, p, s);
        n_cmp++; if (p !== 12'd30) begin n_err++; $display("FAIL mid_next_product got=%0d exp=30", p); end
        n_cmp++; if (e !== 4) begin n_err++; $display("FAIL mid_next_latency got=%0d exp=4", e); end
        release_op();
    endtask

    task automatic test_back_to_back();
        logic [5:0]  va [3] = '{6'd12, 6'd33, 6'd0};
        logic [5:0]  vb [3] = '{6'd12, 6'd2, 6'd0};
        logic [11:0] vp [3] = '{12'd144, 12'd66, 12'd0};
        int          acc_cyc [3] = '{default: 0};
        logic [11:0] got [3] = '{default: 12'hfff};
        int          n_acc = 0;
        int          n_out = 0;
        logic        rdy;
        bus.a = va[0];
        bus.b = vb[0];
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            rdy = bus.in_ready && bus.in_valid;
            @(posedge clk); #1;
            if (rdy) begin
                if (n_acc < 3) acc_cyc[n_acc] = c;
                n_acc++;
                if (n_acc < 3) begin
                    bus.a = va[n_acc];
                    bus.b = vb[n_acc];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            if (bus.out_valid) begin
                if (n_out < 3) got[n_out] = bus.product;
                n_out++;
            end
        end
        bus.out_ready = 1'b0;
        n_cmp++; if (n_acc !== 3) begin n_err++; $display("FAIL b2b_accepts got=%0d exp=3", n_acc); end
        n_cmp++; if (n_out !== 3) begin n_err++; $display("FAIL b2b_outputs got=%0d exp=3", n_out); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (got[i] !== vp[i]) begin n_err++; $display("FAIL b2b_product[%0d] got=%0d exp=%0d", i, got[i], vp[i]); end
        end
        n_cmp++; if (acc_cyc[1] - acc_cyc[0] !== 6) begin n_err++; $display("FAIL b2b_spacing01 got=%0d exp=6", acc_cyc[1] - acc_cyc[0]); end
        n_cmp++; if (acc_cyc[2] - acc_cyc[1] !== 6) begin n_err++; $display("FAIL b2b_spacing12 got=%0d exp=6", acc_cyc[2] - acc_cyc[1]); end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.out_ready = 1'b0;
        bus0.in_valid = 1'b0;
        bus0.a = '0;
        bus0.b = '0;
        bus0.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_extremes();
        test_zero_skip();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
